lpc_host: RTL

//  LPC host (initiator) for TPM-locality cycles. It is the other end of lpc_periph.

---
 rtl/lpc_host_pkg.sv | 47 ++++
 rtl/lpc_host.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lpc_host_pkg.sv
// Shared LPC host definitions: field codes, SYNC codes, FSM states, status codes.
package lpc_host_pkg;

    // START / CYCTYPE field codes
    localparam logic [3:0] START_TPM  = 4'b0101;
    localparam logic [3:0] CYC_READ   = 4'b0000;
    localparam logic [3:0] CYC_WRITE  = 4'b0010;

    // SYNC codes driven by the peripheral
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    // Completion status
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SYNC    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_CYCTYPE   = 4'd2,
        ST_ADDR      = 4'd3,
        ST_WDATA     = 4'd4,
        ST_HTAR      = 4'd5,
        ST_SYNC      = 4'd6,
        ST_RDATA     = 4'd7,
        ST_PTAR      = 4'd8,
        ST_DONE      = 4'd9,
        ST_ABORT     = 4'd10,
        ST_ABORT_REC = 4'd11
    } lpc_state_t;

    // Address nibble idx counted from the top: idx 0 -> [15:12], idx 3 -> [3:0]
    function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = addr[15:12];
            2'd1:    nib = addr[11:8];
            2'd2:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/lpc_host.sv
// LPC host: serialises single-byte TPM read/write requests onto LAD/LFRAME#,
// follows the peripheral SYNC handshake and reports data/status.
module lpc_host
    import lpc_host_pkg::*;
#(
    parameter logic [3:0] START_FIELD    = START_TPM,
    parameter int         SHORT_WAIT_MAX = 8,
    parameter int         LONG_WAIT_MAX  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i
);

    localparam int WAIT_W = $clog2(LONG_WAIT_MAX + 1);

    lpc_state_t        state_reg, state_next;
    logic [1:0]        nib_reg, nib_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              long_reg, long_next;
    logic              we_reg, we_next;
    logic [15:0]       addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [7:0]        rdata_reg, rdata_next;
    logic              serr_reg, serr_next;
    logic [7:0]        rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]        rsp_err_reg, rsp_err_next;
    logic [WAIT_W-1:0] wait_limit;

    assign rsp_rdata_o = rsp_rdata_reg;
    assign rsp_err_o   = rsp_err_reg;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            nib_reg       <= '0;
            wait_reg      <= '0;
            long_reg      <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= 8'hFF;
            serr_reg      <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            nib_reg       <= nib_next;
            wait_reg      <= wait_next;
            long_reg      <= long_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            serr_reg      <= serr_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Next-state logic and bus outputs; long mode is sticky once 0110 is seen
    always_comb begin
        state_next     = state_reg;
        nib_next       = nib_reg;
        wait_next      = wait_reg;
        long_next      = long_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        serr_next      = serr_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        lframe_o       = 1'b1;
        lad_o          = 4'hF;
        lad_oe_o       = 1'b0;
        wait_limit     = (long_reg || lad_i == SYNC_LONG) ? WAIT_W'(LONG_WAIT_MAX)
                                                          : WAIT_W'(SHORT_WAIT_MAX);
        case (state_reg)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_next    = req_we_i;
                    addr_next  = req_addr_i;
                    wdata_next = req_wdata_i;
                    rdata_next = 8'hFF;
                    serr_next  = 1'b0;
                    nib_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                lframe_o   = 1'b0;
                lad_oe_o   = 1'b1;
                lad_o      = START_FIELD;
                state_next = ST_CYCTYPE;
            end
            ST_CYCTYPE: begin
                lad_oe_o   = 1'b1;
                lad_o      = we_reg ? CYC_WRITE : CYC_READ;
                nib_next   = '0;
                state_next = ST_ADDR;
            end
            ST_ADDR: begin
                lad_oe_o = 1'b1;
                lad_o    = addr_nibble(addr_reg, nib_reg);
                nib_next = nib_reg + 2'd1;
                if (nib_reg == 2'd3) begin
                    state_next = we_reg ? ST_WDATA : ST_HTAR;
                end
            end
            ST_WDATA: begin
                lad_oe_o = 1'b1;
                lad_o    = nib_reg[0] ? wdata_reg[7:4] : wdata_reg[3:0];
                nib_next = nib_reg + 2'd1;
                if (nib_reg[0]) begin
                    nib_next   = '0;
                    state_next = ST_HTAR;
                end
            end
            ST_HTAR: begin
                lad_oe_o = (nib_reg == 2'd0);
                nib_next = nib_reg + 2'd1;
                if (nib_reg[0]) begin
                    wait_next  = '0;
                    long_next  = 1'b0;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                nib_next = '0;
                case (lad_i)
                    SYNC_READY: state_next = we_reg ? ST_PTAR : ST_RDATA;
                    SYNC_ERROR: begin
                        serr_next  = 1'b1;
                        state_next = we_reg ? ST_PTAR : ST_RDATA;
                    end
                    SYNC_SHORT, SYNC_LONG: begin
                        if (lad_i == SYNC_LONG) long_next = 1'b1;
                        if (wait_reg == wait_limit) state_next = ST_ABORT;
                        else                        wait_next  = wait_reg + 1'b1;
                    end
                    default: state_next = ST_ABORT;
                endcase
            end
            ST_RDATA: begin
                nib_next = nib_reg + 2'd1;
                if (nib_reg[0]) begin
                    rdata_next = {lad_i, rdata_reg[3:0]};
                    nib_next   = '0;
                    state_next = ST_PTAR;
                end else begin
                    rdata_next = {rdata_reg[7:4], lad_i};
                end
            end
            ST_PTAR: begin
                nib_next = nib_reg + 2'd1;
                if (nib_reg[0]) begin
                    rsp_rdata_next = rdata_reg;
                    rsp_err_next   = serr_reg ? ERR_SYNC : ERR_OK;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                state_next  = ST_IDLE;
            end
            ST_ABORT: begin
                lframe_o = 1'b0;
                lad_oe_o = 1'b1;
                nib_next = nib_reg + 2'd1;
                if (nib_reg == 2'd3) state_next = ST_ABORT_REC;
            end
            ST_ABORT_REC: begin
                rsp_rdata_next = 8'hFF;
                rsp_err_next   = ERR_TIMEOUT;
                state_next     = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
